// File: rtl/m65_kbd_matrix_scanner_pkg.sv
// Shared constants, scan FSM encoding and key numbers for the MEGA65 keyboard matrix.
// Key number = col*8 + row; the same numbers are used by the keyboard adapter in main.
package m65_kbd_pkg;

    localparam int NUM_COLS = 10;
    localparam int NUM_ROWS = 8;
    localparam int NUM_KEYS = 80;
    localparam int COL_W    = 4;
    localparam int KEY_W    = 7;

    typedef enum logic [1:0] {
        DRIVE   = 2'd0,
        SAMPLE  = 2'd1,
        RELEASE = 2'd2
    } scan_state_e;

    localparam int m65_ins_del  = 0;
    localparam int m65_return   = 1;
    localparam int m65_5        = 16;
    localparam int m65_p        = 41;
    localparam int m65_1        = 56;
    localparam int m65_2        = 59;
    localparam int m65_space    = 60;
    localparam int m65_run_stop = 63;

    // Active-low one-hot column drive for the given column.
    function automatic logic [NUM_COLS-1:0] col_drive_n(input logic [COL_W-1:0] col);
        return ~(NUM_COLS'(1) << col);
    endfunction

endpackage

// File: rtl/m65_kbd_matrix_scanner_if.sv
// Matrix drive/sense and key-stream signals of the keyboard scanner.
// Names are from the scanner's point of view (master = scanner).
interface m65_kbd_matrix_scanner_if;
    import m65_kbd_pkg::*;

    logic [NUM_COLS-1:0] col_n_o;
    logic [NUM_ROWS-1:0] row_n_i;
    logic [KEY_W-1:0]    key_num_o;
    logic                key_pressed_n_o;
    logic                scan_done_o;

    modport master (
        output col_n_o,
        output key_num_o,
        output key_pressed_n_o,
        output scan_done_o,
        input  row_n_i
    );

    modport slave (
        input  col_n_o,
        input  key_num_o,
        input  key_pressed_n_o,
        input  scan_done_o,
        output row_n_i
    );

endinterface

// File: rtl/m65_kbd_matrix_scanner_debounce_col.sv
// Debounce for the 8 keys of one matrix column, updated on each sample strobe.
// M65_KBD_DEBOUNCE_EN selects counter debounce; otherwise the state follows raw.
module m65_kbd_debounce_col
    import m65_kbd_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                clk_main_i,
    input  logic                reset_i,
    input  logic                sample_i,
    input  logic [NUM_ROWS-1:0] raw_i,
    output logic [NUM_ROWS-1:0] state_o
);

    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce_scans
        $error("DEBOUNCE_SCANS must be in 1..15");
    end

    logic [NUM_ROWS-1:0] state_q, state_d;

`ifdef M65_KBD_DEBOUNCE_EN
    logic [3:0] cnt_q [NUM_ROWS];
    logic [3:0] cnt_d [NUM_ROWS];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_i) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (raw_i[r] == state_q[r]) begin
                    cnt_d[r] = '0;
                end else if (cnt_q[r] == 4'(DEBOUNCE_SCANS - 1)) begin
                    state_d[r] = raw_i[r];
                    cnt_d[r]   = '0;
                end else begin
                    cnt_d[r] = cnt_q[r] + 4'd1;
                end
            end
        end
    end

    // NOTE: the counter array is reset explicitly; partial debounce progress must not survive reset.
    always_ff @(posedge clk_main_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= '0;
            for (int r = 0; r < NUM_ROWS; r++) cnt_q[r] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        if (sample_i) state_d = raw_i;
    end

    always_ff @(posedge clk_main_i or posedge reset_i) begin
        if (reset_i) state_q <= '0;
        else         state_q <= state_d;
    end
`endif

    assign state_o = state_q;

endmodule

// File: rtl/m65_kbd_matrix_scanner.sv
// MEGA65 keyboard matrix scanner: drives columns, debounces rows, streams key states.
// Optional counter debounce is enabled by defining M65_KBD_DEBOUNCE_EN.
module m65_kbd_matrix_scanner
    import m65_kbd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                      clk_main_i,
    input  logic                      reset_i,
    m65_kbd_matrix_scanner_if.master  kbd
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES);

    if (SETTLE_CYCLES < 4) begin : g_bad_settle_cycles
        $error("SETTLE_CYCLES must be at least 4");
    end

    scan_state_e         state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [NUM_ROWS-1:0] row_meta_q, row_meta_d;
    logic [NUM_ROWS-1:0] row_sync_q, row_sync_d;
    logic [KEY_W-1:0]    key_num_q, key_num_d;
    logic                key_pressed_n_q, key_pressed_n_d;
    logic                sample_strobe;
    logic [NUM_KEYS-1:0] key_state;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        settle_d      = settle_q;
        sample_strobe = 1'b0;
        unique case (state_q)
            DRIVE: begin
                if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                sample_strobe = 1'b1;
                state_d       = RELEASE;
            end
            RELEASE: begin
                state_d = DRIVE;
                col_d   = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;
            end
            default: state_d = DRIVE;
        endcase
    end

    // Rows are asynchronous to the clock, so two flops precede any use.
    assign row_meta_d = kbd.row_n_i;
    assign row_sync_d = row_meta_q;

    // Emitter counter runs independently of the scan; the pair is registered together.
    always_comb begin
        key_num_d       = (key_num_q == KEY_W'(NUM_KEYS - 1)) ? '0 : key_num_q + 1'b1;
        key_pressed_n_d = ~key_state[key_num_d];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_main_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= DRIVE;
            col_q           <= '0;
            settle_q        <= '0;
            row_meta_q      <= '1;
            row_sync_q      <= '1;
            key_num_q       <= '0;
            key_pressed_n_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            settle_q        <= settle_d;
            row_meta_q      <= row_meta_d;
            row_sync_q      <= row_sync_d;
            key_num_q       <= key_num_d;
            key_pressed_n_q <= key_pressed_n_d;
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        m65_kbd_debounce_col #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
        ) u_debounce (
            .clk_main_i (clk_main_i),
            .reset_i    (reset_i),
            .sample_i   (sample_strobe && (col_q == COL_W'(c))),
            .raw_i      (~row_sync_q),
            .state_o    (key_state[c*NUM_ROWS +: NUM_ROWS])
        );
    end

    // Reset gates the drive directly so the matrix is released without waiting for a clock.
    assign kbd.col_n_o         = (reset_i || state_q != DRIVE) ? '1 : col_drive_n(col_q);
    assign kbd.scan_done_o     = (state_q == RELEASE) && (col_q == COL_W'(NUM_COLS - 1));
    assign kbd.key_num_o       = key_num_q;
    assign kbd.key_pressed_n_o = key_pressed_n_q;

endmodule

// File: tb/tb_m65_kbd_matrix_scanner.sv
// Directed testbench for m65_kbd_matrix_scanner with a behavioural key matrix.
// Expectations follow M65_KBD_DEBOUNCE_EN: a key flips after 3 passes if defined, else 1.
module tb_m65_kbd_matrix_scanner;
    import m65_kbd_pkg::*;

`ifdef M65_KBD_DEBOUNCE_EN
    localparam int FLIP = 3;
`else
    localparam int FLIP = 1;
`endif

    logic                clk;
    logic                rst;
    logic [NUM_KEYS-1:0] tb_keys;
    logic                noise_en;
    logic [NUM_ROWS-1:0] noise_val;
    int                  assert_cnt = 0;
    int                  fail_cnt   = 0;

    m65_kbd_matrix_scanner_if kbd ();

    m65_kbd_matrix_scanner dut (
        .clk_main_i (clk),
        .reset_i    (rst),
        .kbd        (kbd.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always @* begin : matrix_model
        logic [NUM_ROWS-1:0] rows;
        rows = '1;
        for (int c = 0; c < NUM_COLS; c++)
            for (int r = 0; r < NUM_ROWS; r++)
                if (!kbd.col_n_o[c] && tb_keys[c*NUM_ROWS + r]) rows[r] = 1'b0;
        if (noise_en) rows = noise_val;
        kbd.row_n_i = rows;
    end

    initial begin
        forever begin
            #($urandom_range(1, 23));
            if (noise_en) noise_val = 8'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        tb_keys = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_col_n", 32'(kbd.col_n_o), 32'h3FF);
        check("rst_key_num", 32'(kbd.key_num_o), 32'd0);
        check("rst_pressed_n", 32'(kbd.key_pressed_n_o), 32'd1);
        check("rst_scan_done", 32'(kbd.scan_done_o), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_scan_done();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            #1;
            if (kbd.scan_done_o) break;
        end
        check("scan_done_seen", 32'(kbd.scan_done_o), 32'd1);
    endtask

    task automatic wait_passes(input int n);
        for (int p = 0; p < n; p++) wait_scan_done();
    endtask

    task automatic expect_key(input string tag, input int k, input int exp_n);
        for (int i = 0; i < 100; i++) begin
            if (kbd.key_num_o == KEY_W'(k)) break;
            @(negedge clk);
            #1;
        end
        check({tag, "_key_num"}, 32'(kbd.key_num_o), 32'(k));
        check(tag, 32'(kbd.key_pressed_n_o), 32'(exp_n));
    endtask

    initial begin
        rst       = 1'b1;
        tb_keys   = '0;
        noise_en  = 1'b0;
        noise_val = '1;

        // Stream order, scan timing, single-column drive.
        do_reset();
        begin
            int first_done = -1;
            int second_done = -1;
            int done_cnt = 0;
            for (int i = 0; i < 1400; i++) begin
                if (i < 200) begin
                    check("t4_key_num", 32'(kbd.key_num_o), 32'(i % 80));
                    check("t4_idle_pressed_n", 32'(kbd.key_pressed_n_o), 32'd1);
                end
                check("t4_col_onehot", 32'($countones(~kbd.col_n_o) <= 1), 32'd1);
                if (i == 63) check("t4_col0_last_drive", 32'(kbd.col_n_o), 32'h3FE);
                if (i == 65) check("t4_col0_release", 32'(kbd.col_n_o), 32'h3FF);
                if (i == 66) check("t4_col1_drive", 32'(kbd.col_n_o), 32'h3FD);
                if (kbd.scan_done_o) begin
                    done_cnt++;
                    if (first_done < 0) first_done = i;
                    else if (second_done < 0) second_done = i;
                end
                @(negedge clk);
                #1;
            end
            check("t4_first_done", 32'(first_done), 32'd659);
            check("t4_done_period", 32'(second_done - first_done), 32'd660);
            check("t4_done_count", 32'(done_cnt), 32'd2);
        end

        // Key 56 held for 5 passes.
        do_reset();
        tb_keys[m65_1] = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            wait_scan_done();
            expect_key("t1_key56", m65_1, (p >= FLIP) ? 0 : 1);
        end
        expect_key("t1_key57", 57, 1);
        expect_key("t1_key79", 79, 1);
        expect_key("t1_key0", 0, 1);
        expect_key("t1_key48", 48, 1);

        // Key 56 held for exactly two passes.
        do_reset();
        tb_keys[m65_1] = 1'b1;
        wait_scan_done();
        expect_key("t2_pass1", m65_1, (FLIP == 1) ? 0 : 1);
        wait_scan_done();
        tb_keys[m65_1] = 1'b0;
        expect_key("t2_pass2", m65_1, (FLIP == 1) ? 0 : 1);
        wait_scan_done();
        expect_key("t2_pass3", m65_1, 1);
        wait_scan_done();
        expect_key("t2_pass4", m65_1, 1);

        // Keys 56 and 57 in the same column.
        do_reset();
        tb_keys[56] = 1'b1;
        tb_keys[57] = 1'b1;
        wait_passes(FLIP);
        expect_key("t3_both_56", 56, 0);
        expect_key("t3_both_57", 57, 0);
        tb_keys[57] = 1'b0;
        wait_passes(FLIP);
        expect_key("t3_hold_56", 56, 0);
        expect_key("t3_rel_57", 57, 1);
        tb_keys[56] = 1'b0;
        wait_passes(FLIP);
        expect_key("t3_rel_56", 56, 1);
        expect_key("t3_still_57", 57, 1);

        // Reset during DRIVE of column 5 with key 56 pressed.
        do_reset();
        tb_keys[m65_1] = 1'b1;
        wait_passes(FLIP);
        expect_key("t5_pre", m65_1, 0);
        for (int i = 0; i < 800; i++) begin
            if (kbd.col_n_o == col_drive_n(COL_W'(5))) break;
            @(negedge clk);
            #1;
        end
        check("t5_col5_driven", 32'(kbd.col_n_o), 32'h3DF);
        rst = 1'b1;
        #1;
        check("t5_async_col_n", 32'(kbd.col_n_o), 32'h3FF);
        check("t5_async_pressed_n", 32'(kbd.key_pressed_n_o), 32'd1);
        check("t5_async_key_num", 32'(kbd.key_num_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_restart_col0", 32'(kbd.col_n_o), 32'h3FE);
        expect_key("t5_released", m65_1, 1);
        wait_passes(FLIP);
        expect_key("t5_redebounced", m65_1, 0);

        // Asynchronous row noise, then quiet matrix.
        do_reset();
        noise_en = 1'b1;
        for (int i = 0; i < 1980; i++) begin
            check("t6_no_x", 32'($isunknown({kbd.col_n_o, kbd.key_num_o,
                                              kbd.key_pressed_n_o, kbd.scan_done_o})), 32'd0);
            @(negedge clk);
            #1;
        end
        noise_en = 1'b0;
        wait_passes(FLIP + 1);
        for (int k = 0; k < NUM_KEYS; k++) expect_key("t6_quiet", k, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
